// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit (with package alu_unit_pkg)
// Description : Combinational N-bit arithmetic/logic unit of the simple-viii
//               datapath. It returns the result, carry and zero flags in the
//               same cycle as the operands arrive. An optional carry register
//               (cq) keeps the previous carry so that multi-byte ADC/SBC chains
//               can be built.
//
// Build option: ALU_CARRY_CHAIN_EN
//               defined   -> the cq flip-flop exists and ADC/SBC consume it.
//               undefined -> no flip-flops, clk/rst unused, ADC == ADD and
//                            SBC == SUB (flags included).
//
// Ports       : clk       in  1   carry register clock (rising edge)
//               rst       in  1   asynchronous active-high reset, clears cq
//               op        in  4   alu_op_e operation select
//               register1 in  N   operand A
//               register2 in  N   operand B
//               result    out N   operation result
//               is_carry  out 1   carry / borrow / shift-out
//               is_zero   out 1   flag value is all zeros (A-B for CMP,
//                                 result otherwise)
//
// Revision    : 1.0 - initial release
// ============================================================================

package alu_unit_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_ADC  = 4'd2,
        ALU_SBC  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOT  = 4'd7,
        ALU_SHL  = 4'd8,
        ALU_SHR  = 4'd9,
        ALU_ROL  = 4'd10,
        ALU_ROR  = 4'd11,
        ALU_INC  = 4'd12,
        ALU_DEC  = 4'd13,
        ALU_PASS = 4'd14,
        ALU_CMP  = 4'd15
    } alu_op_e;
endpackage

module alu_unit #(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  alu_unit_pkg::alu_op_e         op,
    input  logic [DATA_BUS_WIDTH-1:0]     register1,
    input  logic [DATA_BUS_WIDTH-1:0]     register2,
    output logic [DATA_BUS_WIDTH-1:0]     result,
    output logic                          is_carry,
    output logic                          is_zero
);
    import alu_unit_pkg::*;

    localparam int c_W = DATA_BUS_WIDTH;
    localparam logic [c_W-1:0] c_ONE = {{(c_W-1){1'b0}}, 1'b1};

    // Rotates need at least two bits to have distinct MSB and LSB.
    if (DATA_BUS_WIDTH < 2) begin : g_width_check
        $error("alu_unit: DATA_BUS_WIDTH must be at least 2");
    end

    logic           w_cq;       // stored carry, or 0 when chaining is absent
    logic [c_W:0]   w_add;      // A+B with carry-out in bit c_W
    logic [c_W:0]   w_adc;      // A+B+cq
    logic [c_W:0]   w_sub;      // A-B, bit c_W set on borrow
    logic [c_W:0]   w_sbc;      // A-B-cq
    logic [c_W-1:0] w_result;
    logic           w_carry;
    logic [c_W-1:0] w_flag;

    // ------------------------------------------------------------------------
    // Carry register
    // ------------------------------------------------------------------------
`ifdef ALU_CARRY_CHAIN_EN
    logic r_cq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cq <= 1'b0;
        end else begin
            r_cq <= w_carry;
        end
    end

    assign w_cq = r_cq;
`else
    // Without chaining there is no state; clk and rst are intentionally idle.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;
    assign w_cq             = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Arithmetic at c_W+1 bits. For the subtractions the extra bit is the
    // sign of the true difference, which is exactly the borrow: the smallest
    // possible value (0 - max - 1 = -2^N) still lands with bit c_W set.
    // ------------------------------------------------------------------------
    assign w_add = {1'b0, register1} + {1'b0, register2};
    assign w_adc = w_add + {{c_W{1'b0}}, w_cq};
    assign w_sub = {1'b0, register1} - {1'b0, register2};
    assign w_sbc = w_sub - {{c_W{1'b0}}, w_cq};

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        unique0 case (op)
            ALU_ADD: begin
                w_result = w_add[c_W-1:0];
                w_carry  = w_add[c_W];
            end
            ALU_SUB: begin
                w_result = w_sub[c_W-1:0];
                w_carry  = w_sub[c_W];
            end
            ALU_ADC: begin
                w_result = w_adc[c_W-1:0];
                w_carry  = w_adc[c_W];
            end
            ALU_SBC: begin
                w_result = w_sbc[c_W-1:0];
                w_carry  = w_sbc[c_W];
            end
            ALU_AND: w_result = register1 & register2;
            ALU_OR:  w_result = register1 | register2;
            ALU_XOR: w_result = register1 ^ register2;
            ALU_NOT: w_result = ~register1;
            ALU_SHL: begin
                w_result = {register1[c_W-2:0], 1'b0};
                w_carry  = register1[c_W-1];
            end
            ALU_SHR: begin
                w_result = {1'b0, register1[c_W-1:1]};
                w_carry  = register1[0];
            end
            ALU_ROL: begin
                w_result = {register1[c_W-2:0], register1[c_W-1]};
                w_carry  = register1[c_W-1];
            end
            ALU_ROR: begin
                w_result = {register1[0], register1[c_W-1:1]};
                w_carry  = register1[0];
            end
            ALU_INC: begin
                w_result = register1 + c_ONE;
                w_carry  = &register1;
            end
            ALU_DEC: begin
                w_result = register1 - c_ONE;
                w_carry  = ~|register1;
            end
            ALU_PASS: w_result = register2;
            ALU_CMP: begin
                // A passes through untouched; only the flags see A-B.
                w_result = register1;
                w_carry  = w_sub[c_W];
            end
            default: begin
                // Unknown op: result 0 / carry 0, hence is_zero = 1.
                w_result = '0;
                w_carry  = 1'b0;
            end
        endcase
    end

    assign w_flag   = (op == ALU_CMP) ? w_sub[c_W-1:0] : w_result;

    assign result   = w_result;
    assign is_carry = w_carry;
    assign is_zero  = ~|w_flag;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Self-checking bench for alu_unit. Directed vectors from the
//               datasheet values, carry-chain and asynchronous reset scenarios,
//               then randomized traffic compared against an integer-arithmetic
//               reference model with its own carry state.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;
    import alu_unit_pkg::*;

    localparam int N    = 8;
    localparam int MASK = (1 << N) - 1;
    localparam int HALF = 1 << (N - 1);
`ifdef ALU_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    alu_op_e        op  = ALU_ADD;
    logic [N-1:0]   register1 = '0;
    logic [N-1:0]   register2 = '0;
    logic [N-1:0]   result;
    logic           is_carry;
    logic           is_zero;

    int n_cmp = 0;
    int n_bad = 0;

    logic           m_cq = 1'b0;     // model of the stored carry
    logic [N+1:0]   m_next;
    logic [N+1:0]   exp_v;

    alu_unit #(.DATA_BUS_WIDTH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .register1 (register1),
        .register2 (register2),
        .result    (result),
        .is_carry  (is_carry),
        .is_zero   (is_zero)
    );

    always #5 clk = ~clk;

    // Reference: returns {zero, carry, result} from plain integer arithmetic.
    function automatic logic [N+1:0] ref_alu(input int o, input int a,
                                             input int b, input logic cq);
        int r, c, z, d, ci;
        ci = (CHAIN && cq) ? 1 : 0;
        d  = a - b;
        c  = 0;
        case (o)
            0:  begin r = a + b;       c = (r > MASK) ? 1 : 0; end
            1:  begin r = a - b;       c = (a < b) ? 1 : 0; end
            2:  begin r = a + b + ci;  c = (r > MASK) ? 1 : 0; end
            3:  begin r = a - b - ci;  c = (a < b + ci) ? 1 : 0; end
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = MASK - a;
            8:  begin r = a * 2;                   c = a / HALF; end
            9:  begin r = a / 2;                   c = a % 2; end
            10: begin r = a * 2 + a / HALF;        c = a / HALF; end
            11: begin r = a / 2 + (a % 2) * HALF; c = a % 2; end
            12: begin r = a + 1; c = (a == MASK) ? 1 : 0; end
            13: begin r = a - 1; c = (a == 0) ? 1 : 0; end
            14: r = b;
            15: begin r = a; c = (a < b) ? 1 : 0; end
            default: r = 0;
        endcase
        r = r & MASK;
        z = (o == 15) ? (((d & MASK) == 0) ? 1 : 0) : ((r == 0) ? 1 : 0);
        return {z[0], c[0], r[N-1:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        m_next = ref_alu(int'(op), int'(register1), int'(register2), m_cq);
        if (rst) m_cq <= 1'b0;
        else     m_cq <= CHAIN ? m_next[N] : 1'b0;
    end

    task automatic drive(input alu_op_e o, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        op = o; register1 = a; register2 = b;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(ALU_ADC, 8'h00, 8'h00);
        n_cmp++;
        if ({is_zero, is_carry, result} !== {1'b1, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_adc: got z=%0b c=%0b r=%h, want z=1 c=0 r=00",
                     is_zero, is_carry, result);
        end
        drive(ALU_SBC, 8'h00, 8'h00);
        n_cmp++;
        if ({is_zero, is_carry, result} !== {1'b1, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_sbc: got z=%0b c=%0b r=%h, want z=1 c=0 r=00",
                     is_zero, is_carry, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        alu_op_e      o;
        logic [N-1:0] a, b, r;
        logic         c, z;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{ALU_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1});
        v.push_back('{ALU_ADD,  8'h12, 8'h34, 8'h46, 1'b0, 1'b0});
        v.push_back('{ALU_SUB,  8'h05, 8'h07, 8'hFE, 1'b1, 1'b0});
        v.push_back('{ALU_CMP,  8'h42, 8'h42, 8'h42, 1'b0, 1'b1});
        v.push_back('{ALU_CMP,  8'h05, 8'h07, 8'h05, 1'b1, 1'b0});
        v.push_back('{ALU_AND,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0});
        v.push_back('{ALU_OR,   8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0});
        v.push_back('{ALU_XOR,  8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0});
        v.push_back('{ALU_NOT,  8'hF0, 8'h3C, 8'h0F, 1'b0, 1'b0});
        v.push_back('{ALU_SHL,  8'h81, 8'h55, 8'h02, 1'b1, 1'b0});
        v.push_back('{ALU_SHR,  8'h81, 8'h55, 8'h40, 1'b1, 1'b0});
        v.push_back('{ALU_ROL,  8'h81, 8'h55, 8'h03, 1'b1, 1'b0});
        v.push_back('{ALU_ROR,  8'h81, 8'h55, 8'hC0, 1'b1, 1'b0});
        v.push_back('{ALU_INC,  8'hFF, 8'h55, 8'h00, 1'b1, 1'b1});
        v.push_back('{ALU_DEC,  8'h00, 8'h55, 8'hFF, 1'b1, 1'b0});
        v.push_back('{ALU_PASS, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1});
        v.push_back('{ALU_PASS, 8'h00, 8'h5A, 8'h5A, 1'b0, 1'b0});
        foreach (v[i]) begin
            drive(v[i].o, v[i].a, v[i].b);
            n_cmp++;
            if ({is_zero, is_carry, result} !== {v[i].z, v[i].c, v[i].r}) begin
                n_bad++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h: got z=%0b c=%0b r=%h, want z=%0b c=%0b r=%h",
                         i, v[i].o, v[i].a, v[i].b, is_zero, is_carry, result,
                         v[i].z, v[i].c, v[i].r);
            end
        end
    endtask

    task automatic test_carry_chain();
        logic [N+1:0] want;
        // ADD overflows, one edge stores the carry, ADC then consumes it.
        drive(ALU_ADD, 8'hFF, 8'h01);
        drive(ALU_ADC, 8'h00, 8'h00);
        want = CHAIN ? {1'b0, 1'b0, 8'h01} : {1'b1, 1'b0, 8'h00};
        n_cmp++;
        if ({is_zero, is_carry, result} !== want) begin
            n_bad++;
            $display("FAIL chain_adc: got z=%0b c=%0b r=%h, want z=%0b c=%0b r=%h",
                     is_zero, is_carry, result, want[N+1], want[N], want[N-1:0]);
        end
        // Borrow chain: 0x00-0x01 borrows, then SBC 0x05-0x02 subtracts it.
        drive(ALU_SUB, 8'h00, 8'h01);
        drive(ALU_SBC, 8'h05, 8'h02);
        want = CHAIN ? {1'b0, 1'b0, 8'h02} : {1'b0, 1'b0, 8'h03};
        n_cmp++;
        if ({is_zero, is_carry, result} !== want) begin
            n_bad++;
            $display("FAIL chain_sbc: got z=%0b c=%0b r=%h, want z=%0b c=%0b r=%h",
                     is_zero, is_carry, result, want[N+1], want[N], want[N-1:0]);
        end
        // Reset between edges while cq holds 1: must clear without a clock.
        drive(ALU_ADD, 8'hFF, 8'h01);
        drive(ALU_ADC, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({is_zero, is_carry, result} !== {1'b1, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL chain_async_rst: got z=%0b c=%0b r=%h, want z=1 c=0 r=00",
                     is_zero, is_carry, result);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(ALU_ADC, 8'h00, 8'h00);
        n_cmp++;
        if ({is_zero, is_carry, result} !== {1'b1, 1'b0, 8'h00}) begin
            n_bad++;
            $display("FAIL chain_after_rst: got z=%0b c=%0b r=%h, want z=1 c=0 r=00",
                     is_zero, is_carry, result);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(alu_op_e'($urandom_range(15, 0)), N'($urandom), N'($urandom));
            exp_v = ref_alu(int'(op), int'(register1), int'(register2), m_cq);
            n_cmp++;
            if ({is_zero, is_carry, result} !== exp_v) begin
                n_bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h cq=%0b: got z=%0b c=%0b r=%h, want z=%0b c=%0b r=%h",
                         i, op, register1, register2, m_cq, is_zero, is_carry, result,
                         exp_v[N+1], exp_v[N], exp_v[N-1:0]);
            end
        end
    endtask

    // Dense ADD/ADC/SUB/SBC chains with occasional asynchronous reset pulses.
    task automatic test_back_to_back();
        alu_op_e ops[4] = '{ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC};
        for (int i = 0; i < 300; i++) begin
            drive(ops[$urandom_range(3, 0)], N'($urandom), N'($urandom));
            if ($urandom_range(15, 0) == 0) begin
                rst = 1'b1;
                #1;
            end
            exp_v = ref_alu(int'(op), int'(register1), int'(register2), m_cq);
            n_cmp++;
            if ({is_zero, is_carry, result} !== exp_v) begin
                n_bad++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h rst=%0b cq=%0b: got z=%0b c=%0b r=%h, want z=%0b c=%0b r=%h",
                         i, op, register1, register2, rst, m_cq, is_zero, is_carry, result,
                         exp_v[N+1], exp_v[N], exp_v[N-1:0]);
            end
            #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_carry_chain();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
